// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Two-requester round-robin arbiter/sequencer driving a shared
//            8-bit combinational ALU; tagged response channel with backpressure.
// Option   : ALU_ARB_ILLEGAL_OP_EN - selects 4'hC..4'hF return 0/0 with RSP_ERR=1
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0_VALID,
  output logic       REQ0_READY,
  input  logic [3:0] REQ0_SEL,
  input  logic [7:0] REQ0_A,
  input  logic [7:0] REQ0_B,
  input  logic       REQ1_VALID,
  output logic       REQ1_READY,
  input  logic [3:0] REQ1_SEL,
  input  logic [7:0] REQ1_A,
  input  logic [7:0] REQ1_B,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic       RSP_ID,
  output logic [7:0] RSP_OUT,
  output logic [3:0] RSP_FLAG,
  output logic       RSP_ERR,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  output logic [3:0] ALU_SEL,
  input  logic [7:0] ALU_OUT,
  input  logic [3:0] ALU_FLAG,
  output logic       BUSY,
  output logic [7:0] OPS_DONE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last;
  logic   grant0;
  logic   grant1;
  logic   illegal_sel;

  // LAST breaks ties only; a lone requester always wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !RESET) begin
      if (REQ0_VALID && (!REQ1_VALID || last)) begin
        grant0 = 1'b1;
      end else if (REQ1_VALID) begin
        grant1 = 1'b1;
      end
    end
  end

  assign REQ0_READY = grant0;
  assign REQ1_READY = grant1;
  assign BUSY       = (state != IDLE);

`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign illegal_sel = (ALU_SEL[3:2] == 2'b11);
`else
  assign illegal_sel = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      last      <= 1'b1;
      ALU_A     <= 8'h00;
      ALU_B     <= 8'h00;
      ALU_SEL   <= 4'h0;
      RSP_VALID <= 1'b0;
      RSP_ID    <= 1'b0;
      RSP_OUT   <= 8'h00;
      RSP_FLAG  <= 4'h0;
      RSP_ERR   <= 1'b0;
      OPS_DONE  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            ALU_SEL <= grant1 ? REQ1_SEL : REQ0_SEL;
            ALU_A   <= grant1 ? REQ1_A   : REQ0_A;
            ALU_B   <= grant1 ? REQ1_B   : REQ0_B;
            RSP_ID  <= grant1;
            last    <= grant1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          // ALU inputs have been stable for a full cycle; sample its outputs.
          RSP_OUT   <= illegal_sel ? 8'h00 : ALU_OUT;
          RSP_FLAG  <= illegal_sel ? 4'h0  : ALU_FLAG;
          RSP_ERR   <= illegal_sel;
          RSP_VALID <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            OPS_DONE  <= OPS_DONE + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
